// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered, handshaked ALU for the human-8bit CPU datapath. It accepts one
//   operation per in_valid/in_ready transfer and presents a registered result
//   until the consumer takes it with out_valid/out_ready. Logic, add/sub and
//   shift ops complete in one cycle. MUL is an iterative shift-add that
//   consumes one bit of B per cycle, so it takes WIDTH+1 cycles.
//
//   Parameters
//     WIDTH   operand/result width in bits (minimum 4)
//     MUL_EN  1 = MUL (op 7) implemented, 0 = op 7 reported as illegal
//
//   Optional build macro
//     ALU_SEQ_CARRY_CHAIN_EN  adds ADC (op 8) and SBC (op 9), which take their
//                             carry/borrow input from flags.C. Without the
//                             macro, ops 8/9 are illegal and no carry-in logic
//                             exists.
//
//   Ports
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready   request handshake (in_ready=1 only when idle)
//     op, a, b, flag_en   opcode, operands, flag-update enable (captured)
//     out_valid/out_ready result handshake
//     res, res_hi         result (res_hi = MUL high half, else 0)
//     out_err             the current result came from an illegal opcode
//     flags               persistent {C,Z,N,V} register
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             out_err,
  output logic [3:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_ADC = 4'd8,
    OP_SBC = 4'd9
  } op_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic               r_err;
  logic [3:0]         r_flags;

  // Iterative multiplier: accumulator, left-shifting multiplicand,
  // right-shifting multiplier, bit counter and the captured flag enable.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_flag_en;

  // ---------------------------------------------------------------------------
  // Single-cycle arithmetic/logic, evaluated on the request inputs so the
  // result can be registered on the transfer edge itself.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_z;
  logic               w_n;
  logic               w_legal;
  logic               w_is_mul;
  logic               w_accept;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic               w_cin;
  logic [WIDTH:0]     w_adc;
  logic [WIDTH:0]     w_sbc;

  // Carry-in comes from the flag register as it stands at capture time.
  assign w_cin = r_flags[3];
  assign w_adc = w_add + {{WIDTH{1'b0}}, w_cin};
  assign w_sbc = w_sub - {{WIDTH{1'b0}}, w_cin};
`endif

  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_legal  = 1'b1;
    w_is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (A < B).
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res = {a[WIDTH-2:0], 1'b0};
        w_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, a[WIDTH-1:1]};
        w_c   = a[0];
      end
      OP_MUL: begin
        if (MUL_EN != 0) begin
          w_is_mul = 1'b1;
        end else begin
          w_legal = 1'b0;
        end
      end
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      OP_ADC: begin
        w_res = w_adc[WIDTH-1:0];
        w_c   = w_adc[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_adc[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SBC: begin
        w_res = w_sbc[WIDTH-1:0];
        w_c   = w_sbc[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sbc[WIDTH-1] != a[WIDTH-1]);
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  assign w_z = (w_res == '0);
  assign w_n = w_res[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Multiplier step. The final bit is added on the same edge that moves to
  // DONE, so the product is registered straight from the next-accumulator
  // value and the total latency stays at WIDTH+1.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_mul_last;
  logic [3:0]         w_mul_flags;

  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_mul_flags = {(w_acc_nxt[2*WIDTH-1:WIDTH] != '0),
                        (w_acc_nxt == '0),
                        w_acc_nxt[WIDTH-1],
                        1'b0};

  assign w_accept = in_valid && (r_state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_mul_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res     <= '0;
      r_res_hi  <= '0;
      r_err     <= 1'b0;
      r_flags   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_flag_en <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_is_mul) begin
          r_acc     <= '0;
          r_mcand   <= {{WIDTH{1'b0}}, a};
          r_mplier  <= b;
          r_cnt     <= '0;
          r_flag_en <= flag_en;
        end else begin
          // Illegal codes leave w_res at zero and never touch the flags.
          r_res    <= w_res;
          r_res_hi <= '0;
          r_err    <= ~w_legal;
          if (w_legal && flag_en) begin
            r_flags <= {w_c, w_z, w_n, w_v};
          end
        end
      end else if (r_state == S_BUSY) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_mul_last) begin
          r_res    <= w_acc_nxt[WIDTH-1:0];
          r_res_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
          r_err    <= 1'b0;
          if (r_flag_en) begin
            r_flags <= w_mul_flags;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign res_hi    = r_res_hi;
  assign out_err   = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       fe_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res;
  logic [7:0] res_hi;
  logic       out_err;
  logic [3:0] flags;

  int unsigned n_checks;
  int unsigned n_errors;
  bit [3:0]    m_flags;

  alu_seq #(
    .WIDTH  (8),
    .MUL_EN (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .flag_en   (fe_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_hi    (res_hi),
    .out_err   (out_err),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the 8-bit operands.
  function automatic void ref_op(input int o, input int x, input int y, input bit fe,
                                 input bit [3:0] fin, output int r, output int h,
                                 output bit e, output bit [3:0] fo);
    int  full;
    int  sx;
    int  sy;
    int  sr;
    int  cin;
    bit  c;
    bit  v;
    bit  z;
    bit  n;
    bit  legal;
    legal = 1'b1;
    c     = 1'b0;
    v     = 1'b0;
    h     = 0;
    full  = 0;
    sr    = 0;
    cin   = fin[3] ? 1 : 0;
    sx    = (x >= 128) ? x - 256 : x;
    sy    = (y >= 128) ? y - 256 : y;
    case (o)
      0: begin full = x + y; c = (full > 255); sr = sx + sy; v = (sr > 127) || (sr < -128); end
      1: begin full = x - y; c = (x < y);      sr = sx - sy; v = (sr > 127) || (sr < -128); end
      2: full = x & y;
      3: full = x | y;
      4: full = x ^ y;
      5: begin full = x * 2; c = (x >= 128); end
      6: begin full = x / 2; c = (x % 2) != 0; end
      7: begin full = x * y; h = full / 256; c = (h != 0); end
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      8: begin full = x + y + cin; c = (full > 255); sr = sx + sy + cin; v = (sr > 127) || (sr < -128); end
      9: begin full = x - y - cin; c = (full < 0);   sr = sx - sy - cin; v = (sr > 127) || (sr < -128); end
`endif
      default: legal = 1'b0;
    endcase
    r = full & 255;
    z = (o == 7) ? (full == 0) : (r == 0);
    n = (r >= 128);
    if (!legal) begin
      r  = 0;
      h  = 0;
      e  = 1'b1;
      fo = fin;
    end else begin
      e  = 1'b0;
      fo = fe ? {c, z, n, v} : fin;
    end
  endfunction

  // Issues one request starting just after a falling edge with the DUT idle,
  // checks latency and result, applies bp cycles of backpressure (with a
  // competing request held on the input), then releases the result.
  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic fe, input int bp,
                        output logic [7:0] gr, output logic [7:0] gh, output logic [3:0] gf);
    int       er;
    int       eh;
    bit       ee;
    bit [3:0] ef;
    int       lat;
    int       exp_lat;
    bit       busy_bad;
    ref_op(int'(o), int'(x), int'(y), fe, m_flags, er, eh, ee, ef);
    check("idle_ready", {31'd0, in_ready}, 1);
    op_i      = o;
    a_i       = x;
    b_i       = y;
    fe_i      = fe;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat      = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && lat < 100);
    exp_lat = (o == 4'd7) ? 9 : 1;
    check("latency", lat, exp_lat);
    if (!out_valid) begin
      $display("FAIL timeout: out_valid never rose (got 0 expected 1)");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "result handshake never completed");
    end
    check("busy_ready", {31'd0, busy_bad}, 0);
    check("res", {24'd0, res}, er);
    check("res_hi", {24'd0, res_hi}, eh);
    check("err", {31'd0, out_err}, {31'd0, ee});
    check("flags", {28'd0, flags}, {28'd0, ef});
    check("done_ready", {31'd0, in_ready}, 0);
    m_flags = ef;
    gr = res;
    gh = res_hi;
    gf = flags;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      op_i     = 4'd0;
      a_i      = 8'($urandom);
      b_i      = 8'($urandom);
      @(negedge clk);
      check("bp_hold", {9'd0, out_valid, in_ready, out_err, flags, res_hi, res},
            {9'd0, 1'b1, 1'b0, ee, ef, eh[7:0], er[7:0]});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // A request held across the output transfer must not be taken yet.
    check("release", {30'd0, out_valid, in_ready}, 2'b01);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] gr;
    logic [7:0] gh;
    logic [3:0] gf;
    n_checks  = 0;
    n_errors  = 0;
    m_flags   = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_i      = '0;
    a_i       = '0;
    b_i       = '0;
    fe_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {11'd0, in_ready, out_valid, out_err, flags, res_hi, res},
          {11'd0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd0, 8'hF0, 8'h20, 1'b1, 0, gr, gh, gf);
    check("add_F0_20", {20'd0, gf, gr}, {20'd0, 4'b1000, 8'h10});
    run_op(4'd1, 8'h05, 8'h07, 1'b1, 0, gr, gh, gf);
    check("sub_05_07", {20'd0, gf, gr}, {20'd0, 4'b1010, 8'hFE});
    run_op(4'd0, 8'h01, 8'h01, 1'b0, 0, gr, gh, gf);
    check("add_noflag", {20'd0, gf, gr}, {20'd0, 4'b1010, 8'h02});
    run_op(4'd7, 8'h12, 8'h34, 1'b1, 0, gr, gh, gf);
    check("mul_12_34", {12'd0, gf, gh, gr}, {12'd0, 4'b1010, 16'h03A8});
    run_op(4'd0, 8'h7F, 8'h01, 1'b1, 5, gr, gh, gf);
    check("add_bp_ovf", {20'd0, gf, gr}, {20'd0, 4'b0011, 8'h80});
    run_op(4'hF, 8'h55, 8'hAA, 1'b1, 0, gr, gh, gf);
    check("illegal_F", {19'd0, out_err, gf, gr}, {19'd0, 1'b1, 4'b0011, 8'h00});
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    run_op(4'd0, 8'hFF, 8'h01, 1'b1, 0, gr, gh, gf);
    check("add_FF_01", {20'd0, gf, gr}, {20'd0, 4'b1100, 8'h00});
    run_op(4'd8, 8'h00, 8'h00, 1'b1, 0, gr, gh, gf);
    check("adc_carry", {20'd0, gf, gr}, {20'd0, 4'b0000, 8'h01});
`else
    run_op(4'd8, 8'h10, 8'h20, 1'b1, 0, gr, gh, gf);
    check("adc_absent", {19'd0, out_err, gf, gr}, {19'd0, 1'b1, 4'b0011, 8'h00});
`endif

    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             1'($urandom), int'($urandom_range(0, 2)), gr, gh, gf);
    end

    // Make sure the flags are non-zero so the reset clearing them is visible.
    run_op(4'd1, 8'h00, 8'h01, 1'b1, 0, gr, gh, gf);
    op_i     = 4'd7;
    a_i      = 8'hFF;
    b_i      = 8'hFF;
    fe_i     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_mul_busy", {30'd0, out_valid, in_ready}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mid_mul_reset", {25'd0, out_valid, in_ready, out_err, flags},
          {25'd0, 1'b0, 1'b1, 1'b0, 4'h0});
    m_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd0, 8'h01, 8'h02, 1'b1, 0, gr, gh, gf);
    check("post_reset_add", {20'd0, gf, gr}, {20'd0, 4'b0000, 8'h03});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
